// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches instruction words from instruction
// memory over a req/ack handshake, holds the fetched word in an instruction
// register with its decoded fields, and selects the next PC from
// jump-register, jump, conditional-branch and sequential targets.
//
// Optional build macro: IFU_ALIGN_CHECK_EN
//   defined   - a misaligned next PC parks the unit in FAULT with align_fault
//               asserted until reset; the PC is left unchanged.
//   undefined - the low two bits of the next PC are forced to zero and
//               align_fault is tied low.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | one cycle after reset release before the first fetch
// S_REQ   | imem_req high at imem_addr = pc, waiting for imem_ack
// S_VALID | IR holds a valid instruction; waits for stall low to advance
// S_FAULT | misaligned target seen, sticky until reset (align check only)

module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              Beq,
    input  logic              Bne,
    input  logic              J,
    input  logic              Z,
    input  logic              jr_valid,
    input  logic [ADDR_W-1:0] jr_target,
    output logic              instr_valid,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc,
    output logic              align_fault
);

`ifdef IFU_ALIGN_CHECK_EN
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_FAULT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID} state_t;
`endif

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [31:0]       ir, ir_nxt;

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_off;
    logic              br_taken;
    logic [ADDR_W-1:0] target_raw;
    logic [ADDR_W-1:0] next_pc;
    logic              misaligned;

    // State, PC and IR registers; reset also aborts any handshake in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    // Next-PC selection: jr beats J beats taken branch beats sequential
    always_comb begin
        pc4        = pc + ADDR_W'(4);
        br_off     = ADDR_W'($signed({{14{ir[15]}}, ir[15:0], 2'b00}));
        br_taken   = (Beq & Z) | (Bne & ~Z);
        target_raw = pc4;
        if (jr_valid)
            target_raw = jr_target;
        else if (J)
            target_raw = {pc4[ADDR_W-1:28], ir[25:0], 2'b00};
        else if (br_taken)
            target_raw = pc4 + br_off;
`ifdef IFU_ALIGN_CHECK_EN
        next_pc    = target_raw;
        misaligned = (target_raw[1:0] != 2'b00);
`else
        // without the checker a word-aligned PC is guaranteed by construction
        next_pc    = target_raw & ~ADDR_W'(3);
        misaligned = 1'b0;
`endif
    end

    // Fetch sequencing; redirects only matter on the VALID -> REQ step
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    ir_nxt    = imem_rdata;
                    state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (!stall) begin
`ifdef IFU_ALIGN_CHECK_EN
                    if (misaligned) begin
                        state_nxt = S_FAULT;
                    end else begin
                        pc_nxt    = next_pc;
                        state_nxt = S_REQ;
                    end
`else
                    pc_nxt    = next_pc;
                    state_nxt = misaligned ? S_IDLE : S_REQ;
`endif
                end
            end
`ifdef IFU_ALIGN_CHECK_EN
            S_FAULT: state_nxt = S_FAULT;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    assign imem_req    = (state == S_REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_VALID);

`ifdef IFU_ALIGN_CHECK_EN
    assign align_fault = (state == S_FAULT);
`else
    assign align_fault = 1'b0;
`endif

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign imm    = ir[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by randomized
// fetches, all compared against a transaction-level model of the PC and IR.

module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        Beq, Bne, J, Z;
    logic        jr_valid;
    logic [31:0] jr_target;
    logic        instr_valid;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        align_fault;

    int          n_checks = 0;
    int          n_errs   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic        m_fault;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .Beq(Beq), .Bne(Bne), .J(J), .Z(Z),
        .jr_valid(jr_valid), .jr_target(jr_target),
        .instr_valid(instr_valid),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .imm(imm), .pc(pc), .align_fault(align_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference next-PC computed straight from the branch/jump rules
    function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] word,
                                               input logic beq, input logic bne, input logic jj,
                                               input logic z, input logic jrv, input logic [31:0] jrt);
        logic [31:0] seq;
        logic [15:0] off16;
        int          off;
        seq   = cur_pc + 32'd4;
        off16 = word[15:0];
        off   = int'($signed(off16)) * 4;
        if (jrv) begin
`ifdef IFU_ALIGN_CHECK_EN
            return jrt;
`else
            return jrt & 32'hFFFF_FFFC;
`endif
        end
        if (jj)
            return (seq & 32'hF000_0000) | ({6'b0, word[25:0]} << 2);
        if ((beq && z) || (bne && !z))
            return seq + 32'(off);
        return seq;
    endfunction

    task automatic wait_req();
        int k;
        k = 0;
        while (imem_req !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        check_eq("req_seen", 32'(imem_req), 32'd1);
    endtask

    // One full fetch: request, ack after dly cycles, nstall stalled cycles
    // with noisy redirects, then release with the given redirect inputs.
    task automatic fetch_one(input logic [31:0] word, input int dly, input int nstall,
                             input logic beq, input logic bne, input logic jj, input logic z,
                             input logic jrv, input logic [31:0] jrt);
        logic [31:0] exp_next;
        wait_req();
        check_eq("imem_addr", imem_addr, m_pc);
        for (int i = 0; i < dly; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            check_eq("req_held", 32'(imem_req), 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        m_ir       = word;
        check_eq("instr_valid", 32'(instr_valid), 32'd1);
        check_eq("req_drop", 32'(imem_req), 32'd0);
        check_eq("pc", pc, m_pc);
        check_eq("ir_fields", {opcode, rs, rt, imm}, m_ir);
        check_eq("rd", 32'(rd), 32'(m_ir[15:11]));
        check_eq("shamt", 32'(shamt), 32'(m_ir[10:6]));
        check_eq("funct", 32'(funct), 32'(m_ir[5:0]));
        for (int i = 0; i < nstall; i++) begin
            stall      = 1'b1;
            Beq        = 1'($urandom);
            Bne        = 1'($urandom);
            J          = ~J;
            Z          = 1'($urandom);
            jr_valid   = 1'($urandom);
            jr_target  = $urandom;
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            @(negedge clk);
            check_eq("stall_valid", 32'(instr_valid), 32'd1);
            check_eq("stall_req", 32'(imem_req), 32'd0);
            check_eq("stall_pc", pc, m_pc);
            check_eq("stall_ir", {opcode, rs, rt, imm}, m_ir);
        end
        stall     = 1'b0;
        imem_ack  = 1'b0;
        Beq       = beq;
        Bne       = bne;
        J         = jj;
        Z         = z;
        jr_valid  = jrv;
        jr_target = jrt;
        exp_next  = model_next(m_pc, m_ir, beq, bne, jj, z, jrv, jrt);
        @(negedge clk);
        Beq       = 1'b0;
        Bne       = 1'b0;
        J         = 1'b0;
        Z         = 1'b0;
        jr_valid  = 1'b0;
        jr_target = '0;
`ifdef IFU_ALIGN_CHECK_EN
        if (exp_next[1:0] != 2'b00) m_fault = 1'b1;
        else                        m_pc    = exp_next;
`else
        m_pc = exp_next;
`endif
        check_eq("align_fault", 32'(align_fault), 32'(m_fault));
    endtask

    initial begin
        logic [31:0] rj;
        rst        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        stall      = 1'b0;
        Beq        = 1'b0;
        Bne        = 1'b0;
        J          = 1'b0;
        Z          = 1'b0;
        jr_valid   = 1'b0;
        jr_target  = '0;
        m_pc       = 32'h0;
        m_ir       = 32'h0;
        m_fault    = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_ir", {opcode, rs, rt, imm}, 32'h0);
        check_eq("rst_align", 32'(align_fault), 32'd0);
        rst = 1'b1;
        check_eq("idle_req", 32'(imem_req), 32'd0);
        @(negedge clk);

        // First fetch with ack in the same cycle as req
        fetch_one(32'h2008_0005, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        check_eq("first_opcode", 32'(opcode), 32'h08);
        check_eq("first_rt", 32'(rt), 32'd8);
        check_eq("first_imm", 32'(imm), 32'h0005);
        check_eq("first_next", imem_addr, 32'h4);

        // Stall with J toggling, then J to 0x100
        fetch_one(32'h0800_0040, 1, 5, 0, 0, 1, 0, 0, 32'h0);
        check_eq("jump_addr", imem_addr, 32'h100);

        // Ack three cycles late, sequential
        fetch_one(32'h0000_0020, 3, 0, 0, 0, 0, 0, 0, 32'h0);
        check_eq("seq_addr", imem_addr, 32'h104);

        fetch_one(32'h8C01_0004, 0, 1, 0, 0, 0, 0, 1, 32'h200);
        check_eq("jr_addr", imem_addr, 32'h200);

        // Backward branch taken and not taken
        fetch_one(32'h1000_FFFE, 0, 0, 1, 0, 0, 1, 0, 32'h0);
        check_eq("beq_taken", imem_addr, 32'h1FC);
        fetch_one(32'h0000_0000, 2, 0, 0, 0, 0, 0, 1, 32'h200);
        fetch_one(32'h1000_FFFE, 0, 0, 1, 0, 0, 0, 0, 32'h0);
        check_eq("beq_not_taken", imem_addr, 32'h204);

        // jr beats J; sequential wrap at the top of the address space
        fetch_one(32'h0800_0040, 0, 0, 0, 0, 1, 0, 1, 32'h3000);
        check_eq("jr_priority", imem_addr, 32'h3000);
        fetch_one(32'h0000_0000, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        check_eq("top_addr", imem_addr, 32'hFFFF_FFFC);
        fetch_one(32'h0000_0000, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        check_eq("wrap_addr", imem_addr, 32'h0);

        // Random fetches, including simultaneous Beq/Bne
        for (int n = 0; n < 40; n++) begin
            rj = $urandom;
`ifdef IFU_ALIGN_CHECK_EN
            rj = rj & 32'hFFFF_FFFC;
`endif
            fetch_one($urandom, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(3, 0) == 0), rj);
        end

        // Reset in the middle of a handshake; an ack during reset is dropped
        wait_req();
        imem_ack = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_eq("midrst_req", 32'(imem_req), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        check_eq("midrst_pc", pc, 32'h0);
        check_eq("midrst_ir", {opcode, rs, rt, imm}, 32'h0);
        check_eq("midrst_valid", 32'(instr_valid), 32'd0);
        rst  = 1'b1;
        m_pc = 32'h0;
        check_eq("midrst_idle", 32'(imem_req), 32'd0);
        @(negedge clk);
        fetch_one(32'h2008_0005, 0, 0, 0, 0, 0, 0, 0, 32'h0);

        // Misaligned jump-register target
        fetch_one(32'h0000_0008, 0, 0, 0, 0, 0, 0, 1, 32'h3002);
`ifdef IFU_ALIGN_CHECK_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("fault_sticky", 32'(align_fault), 32'd1);
            check_eq("fault_req", 32'(imem_req), 32'd0);
            check_eq("fault_valid", 32'(instr_valid), 32'd0);
            check_eq("fault_pc", pc, m_pc);
        end
        #2 rst = 1'b0;
        #1;
        check_eq("fault_cleared", 32'(align_fault), 32'd0);
        @(negedge clk);
        rst = 1'b1;
`else
        check_eq("mask_addr", imem_addr, 32'h3000);
        check_eq("mask_align", 32'(align_fault), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    // Absolute time limit so a wedged run still reports
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
